// File: rtl/memory_arbiter.sv
// Multi-CPU arbiter in front of a single-ported RAM: registered round-robin grant
// FSM, data-over-instruction priority per CPU, BUSY timeout and error/abort reporting.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CPUS-1:0]   iREN,
  input  logic [CPUS-1:0]   dREN,
  input  logic [CPUS-1:0]   dWEN,
  input  logic [CPUS*AW-1:0] iaddr,
  input  logic [CPUS*AW-1:0] daddr,
  input  logic [CPUS*DW-1:0] dstore,
  output logic [CPUS-1:0]   iwait,
  output logic [CPUS-1:0]   dwait,
  output logic [CPUS*DW-1:0] iload,
  output logic [CPUS*DW-1:0] dload,
  output logic [CPUS-1:0]   err,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [AW-1:0]     ramaddr,
  output logic [DW-1:0]     ramstore,
  input  logic [DW-1:0]     ramload,
  input  ramstate_t         ramstate,
  output logic [2:0]        gnt_cpu
);

  typedef enum logic {S_IDLE, S_XFER} state_t;
  typedef enum logic [1:0] {CH_DRD, CH_DWR, CH_IRD} chan_t;

  state_t      state_q, state_d;
  chan_t       chan_q, chan_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  rr_q, rr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [CPUS-1:0] dreq;
  logic [AW-1:0]   g_daddr, g_iaddr;
  logic [DW-1:0]   g_dstore;
  logic            g_dreq, g_ireq, live;
  logic            found, end_xfer, ack, fail;
  logic [2:0]      cand;

  assign dreq    = dREN | dWEN;
  assign iload   = {CPUS{ramload}};
  assign dload   = {CPUS{ramload}};
  assign gnt_cpu = gnt_q;

  // (v + step) mod CPUS, valid for v < CPUS and step < CPUS
  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int step);
    int s;
    s = int'(v) + step;
    if (s >= CPUS) s = s - CPUS;
    return 3'(s);
  endfunction

  always_comb begin
    g_daddr  = '0;
    g_iaddr  = '0;
    g_dstore = '0;
    g_dreq   = 1'b0;
    g_ireq   = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      if (gnt_q == 3'(c)) begin
        g_daddr  = daddr[c*AW +: AW];
        g_iaddr  = iaddr[c*AW +: AW];
        g_dstore = dstore[c*DW +: DW];
        g_dreq   = dreq[c];
        g_ireq   = iREN[c];
      end
    end
  end

  // NOTE: every output and next-state variable is defaulted first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    iwait    = '1;
    dwait    = '1;
    err      = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    found    = 1'b0;
    end_xfer = 1'b0;
    ack      = 1'b0;
    fail     = 1'b0;
    cand     = '0;
    live     = (chan_q == CH_IRD) ? g_ireq : g_dreq;

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        for (int i = 0; i < CPUS; i++) begin
          cand = wrap_inc(rr_q, i);
          for (int c = 0; c < CPUS; c++) begin
            if (!found && cand == 3'(c) && (dreq[c] || iREN[c])) begin
              found  = 1'b1;
              gnt_d  = cand;
              chan_d = !dreq[c] ? CH_IRD : (dWEN[c] ? CH_DWR : CH_DRD);
            end
          end
        end
        if (found) state_d = S_XFER;
      end

      S_XFER: begin
        // Enables are gated by the live request so a dropped request never reaches the RAM.
        ramREN   = live && (chan_q != CH_DWR);
        ramWEN   = live && (chan_q == CH_DWR);
        ramaddr  = (chan_q == CH_IRD) ? g_iaddr : g_daddr;
        ramstore = g_dstore;

        if (!live) begin
          end_xfer = 1'b1;
        end else if (ramstate == ACCESS) begin
          end_xfer = 1'b1;
          ack      = 1'b1;
        end else if (ramstate == ERROR || cnt_q == 8'(TIMEOUT)) begin
          end_xfer = 1'b1;
          ack      = 1'b1;
          fail     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        for (int c = 0; c < CPUS; c++) begin
          if (ack && gnt_q == 3'(c)) begin
            if (chan_q == CH_IRD) iwait[c] = 1'b0;
            else                  dwait[c] = 1'b0;
            err[c] = fail;
          end
        end

        if (end_xfer) begin
          state_d = S_IDLE;
          rr_d    = wrap_inc(gnt_q, 1);
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      chan_q  <= CH_DRD;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Parametrised multi-CPU RAM arbiter. Sits between CPUS instruction/data cache pairs and the single-ported RAM model.
- Replaces purely combinational steering with a registered grant FSM.
- Adds round-robin fairness across CPUs, data-over-instruction priority within a CPU, a BUSY timeout, and ERROR/abort reporting.

Parameters:
CPUS, 2, number of CPUs (1..8); each CPU has one instruction channel and one data channel
AW, 32, address width
DW, 32, data word width
TIMEOUT, 15, max cycles a granted transfer may wait for ACCESS before it is aborted with error (1..255)

Ports:
CLK  in  1  clock; one clock domain
RST  in  1  reset; synchronous, active-high
iREN  in  CPUS  instruction read request per CPU
dREN  in  CPUS  data read request per CPU
dWEN  in  CPUS  data write request per CPU
iaddr  in  CPUS*AW  instruction address, CPU c at bits [c*AW +: AW]
daddr  in  CPUS*AW  data address per CPU
dstore  in  CPUS*DW  write data per CPU
iwait  out  CPUS  instruction wait per CPU (low = transfer complete this cycle)
dwait  out  CPUS  data wait per CPU
iload  out  CPUS*DW  read data per CPU (ramload broadcast)
dload  out  CPUS*DW  read data per CPU (ramload broadcast)
err  out  CPUS  one-cycle pulse: granted transfer of CPU c ended by ERROR or timeout
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
ramload  in  DW  RAM read data
ramstate  in  2  FREE/BUSY/ACCESS/ERROR (cpu_types_pkg ramstate_t)
gnt_cpu  out  3  index of currently granted CPU (0 in IDLE)

Behaviour:
- Reset (RST high at a CLK edge):
  - state IDLE, rr pointer 0, timeout counter 0.
  - All iwait/dwait = 1, err = 0, ramREN = ramWEN = 0, gnt_cpu = 0.
  - Reset mid-transfer aborts silently: no wait-low and no err pulse.
- Channel request:
  - data request = dREN[c] | dWEN[c]. If both are high, the transfer is a write.
  - instruction request = iREN[c].
- State IDLE:
  - Scan CPUs starting at the rr pointer, wrapping modulo CPUS. The first CPU with any request wins.
  - Within that CPU, the data channel beats the instruction channel.
  - Register gnt_cpu and the channel type (D-read, D-write, I-read), then go to XFER. Counter = 0.
  - No request: stay IDLE; RAM enables stay 0.
- State XFER:
  - ramREN = 1 for a read, ramWEN = 1 for a write (never both).
  - ramaddr/ramstore are muxed live from the granted CPU's daddr/dstore, or its iaddr for I-read. Requesters hold address and data stable while waiting.
  - ramstate == ACCESS: drive the granted channel's wait low for exactly that cycle. Next state IDLE; rr pointer = (gnt_cpu+1) mod CPUS.
  - ramstate == ERROR: same as ACCESS, plus err[gnt_cpu] = 1 for that cycle.
  - ramstate == BUSY or FREE: counter++. When counter reaches TIMEOUT, complete as for ERROR (wait low plus err pulse) and go IDLE.
  - Granted request drops before completion: abort. Go IDLE next cycle, RAM enables deassert, no wait-low, no err, rr pointer still advances.
- Wait and data outputs:
  - Every non-granted channel, and every channel in IDLE, holds wait = 1.
  - A channel's wait is never low in two consecutive cycles.
  - iload/dload always equal ramload; valid only when the matching wait is low.
- Latency:
  - Request seen in IDLE at cycle 0 → RAM enables at cycle 1 → earliest completion in cycle 1.
  - Minimum 2 cycles per transfer; IDLE is always visited between transfers.
- Fairness: with all CPUS continuously requesting, each CPU is granted once per CPUS transfers. The instruction channel is served only when its own CPU has no data request at grant time.
- gnt_cpu width is fixed at 3 bits; unused upper bits are 0.

Test Plan:
- CPUS=2, TIMEOUT=15. Reset, then CPU0 iREN, iaddr=0x40, ramstate ACCESS on the first enabled cycle → ramREN=1, ramaddr=0x40 at cycle 1; iwait[0]=0 for one cycle with iload[0]=ramload; back to IDLE.
- CPU0 dWEN+dREN, daddr=0x100, dstore=0xDEADBEEF, together with CPU0 iREN → write granted first: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF. dwait[0] pulses low, then the I-read is served next.
- CPU0 and CPU1 both hold dREN continuously, ACCESS every enabled cycle → grants alternate 0,1,0,1; each dwait goes low every 4th cycle.
- CPU1 dREN, ramstate held BUSY → after 15 XFER cycles, dwait[1]=0 and err[1]=1 for one cycle; the next grant goes to CPU0 if it is requesting.
- CPU0 dREN granted, ramstate ERROR on the first cycle → dwait[0]=0 and err[0]=1 in that same cycle.
- CPU1 iREN granted, BUSY for 3 cycles, iREN dropped → ramREN=0 the next cycle, no iwait-low, no err. Separately, RST asserted mid-XFER → all outputs return to reset values at the next edge.
